// File: rtl/mcc_pkg.sv
// +--------------------------------------------------------------------------+
// | mcc_pkg : shared widths and FIFO entry type for the multicycle computer  |
// | Rev 1.0  (entry carries a timestamp when PROG_OUT_CAPTURE_TSTAMP_EN)     |
// +--------------------------------------------------------------------------+
`default_nettype none

package mcc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TS_WIDTH   = 16;

  typedef struct packed {
`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
    logic [TS_WIDTH-1:0]   ts;
`endif
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with explicit occupancy count               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the head slot, so the write is accepted.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_out_capture.sv
// +--------------------------------------------------------------------------+
// | program_out_capture : records every change of program_out into a FIFO    |
// | Rev 1.0  (optional out_ts port via PROG_OUT_CAPTURE_TSTAMP_EN)           |
// +--------------------------------------------------------------------------+
`default_nettype none

module program_out_capture
  import mcc_pkg::*;
#(
  parameter int DATA_WIDTH     = mcc_pkg::DATA_WIDTH,
  parameter int DEPTH_LOG2     = 3,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     program_out,
  input  logic                      capture_en,
  output logic [DATA_WIDTH-1:0]     out_data,
`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
  output logic [TS_WIDTH-1:0]       out_ts,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DEPTH_LOG2:0]       fifo_count,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
  localparam int ENTRY_W = DATA_WIDTH + TS_WIDTH;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0]     prev_q, prev_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      w_push_req;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_full;
  logic                      w_empty;
  logic [ENTRY_W-1:0]        w_wdata;
  logic [ENTRY_W-1:0]        w_rdata;

  assign w_push_req = capture_en && (program_out != prev_q);
  assign w_pop      = !w_empty && out_ready;
  assign w_drop     = w_push_req && w_full && !w_pop;

`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign w_wdata = {ts_q, program_out};
  assign out_ts  = w_rdata[ENTRY_W-1 -: TS_WIDTH];
`else
  assign w_wdata = program_out;
`endif

  assign out_data   = w_rdata[DATA_WIDTH-1:0];
  assign out_valid  = !w_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_comb begin
    prev_d     = capture_en ? program_out : prev_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (w_drop) begin
      overflow_d = 1'b1;
      if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_push_req),
    .pop_i   (w_pop),
    .wdata_i (w_wdata),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_program_out_capture.sv
// +--------------------------------------------------------------------------+
// | tb_program_out_capture : queue-model bench for program_out_capture       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_program_out_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] program_out = '0;
  logic        capture_en = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
  logic [15:0] out_ts;
`endif

  program_out_capture dut (
    .clock       (clock),
    .reset       (reset),
    .program_out (program_out),
    .capture_en  (capture_en),
    .out_data    (out_data),
`ifdef PROG_OUT_CAPTURE_TSTAMP_EN
    .out_ts      (out_ts),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of captured values plus sticky drop state.
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  logic [31:0] m_prev = '0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    bit full, pop, push;
    if (reset) begin
      mq.delete();
      m_prev  = '0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      full = (mq.size() == 8);
      pop  = (mq.size() > 0) && out_ready;
      push = capture_en && (program_out != m_prev);
      if (capture_en) m_prev = program_out;
      if (pop) begin
        popped.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (push) begin
        if (full && !pop) begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end else begin
          mq.push_back(program_out);
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    if (chk_en) begin
      chk("out_valid",  out_valid,  64'(mq.size() > 0));
      chk("fifo_count", fifo_count, 64'(mq.size()));
      chk("overflow",   overflow,   64'(m_ovf));
      chk("drop_count", drop_count, 64'(m_drops));
      if (mq.size() > 0) chk("out_data", out_data, 64'(mq[0]));
    end
  end

  task automatic cyc(input logic [31:0] po, input logic c, input logic r);
    program_out = po;
    capture_en  = c;
    out_ready   = r;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clock);

    // Reset held with a nonzero bus: everything stays zero.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(32'h1234, 1'b1, 1'b0);
      chk_en = 1'b1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data,  0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf",   overflow,  0);
      chk("rst_drop",  drop_count, 0);
    end
    reset = 1'b0;
    cyc(32'h1234, 1'b1, 1'b0);
    chk("first_valid", out_valid, 1);
    chk("first_data",  out_data, 32'h1234);

    // Repeated value is not captured.
    do_reset();
    popped.delete();
    cyc(32'h1, 1'b1, 1'b1);
    cyc(32'h2, 1'b1, 1'b1);
    cyc(32'h2, 1'b1, 1'b1);
    cyc(32'h3, 1'b1, 1'b1);
    cyc(32'h3, 1'b1, 1'b1);
    cyc(32'h3, 1'b1, 1'b1);
    chk("seq_n", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("seq_0", popped[0], 32'h1);
      chk("seq_1", popped[1], 32'h2);
      chk("seq_2", popped[2], 32'h3);
    end

    // Overflow with stalled sink: two drops, first eight retained.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(32'h10 + 32'(i), 1'b1, 1'b0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_drops", drop_count, 2);
    popped.delete();
    for (int i = 0; i < 10; i++) cyc(32'h19, 1'b1, 1'b1);
    chk("ovf_drain_n", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++) chk("ovf_drain", popped[i], 32'h10 + 32'(i));
    chk("ovf_sticky", overflow, 1);

    // Full with simultaneous push and pop: no drop.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(32'h20 + 32'(i), 1'b1, 1'b0);
    popped.delete();
    cyc(32'h28, 1'b1, 1'b1);
    chk("fpp_count", fifo_count, 8);
    chk("fpp_drops", drop_count, 0);
    chk("fpp_ovf",   overflow, 0);
    for (int i = 0; i < 10; i++) cyc(32'h28, 1'b1, 1'b1);
    chk("fpp_n", popped.size(), 9);
    if (popped.size() == 9) chk("fpp_last", popped[8], 32'h28);

    // Frozen previous value while capture is disabled.
    do_reset();
    cyc(32'h5, 1'b1, 1'b1);
    cyc(32'h5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(32'h6, 1'b0, 1'b1);
    chk("frz_empty", out_valid, 0);
    cyc(32'h6, 1'b1, 1'b0);
    chk("frz_valid", out_valid, 1);
    chk("frz_data",  out_data, 32'h6);
    chk("frz_count", fifo_count, 1);

    // Drop counter saturates.
    do_reset();
    for (int i = 1; i <= 300; i++) cyc(32'(i), 1'b1, 1'b0);
    chk("sat_drops", drop_count, 255);
    chk("sat_count", fifo_count, 8);
    for (int i = 0; i < 9; i++) cyc(32'd300, 1'b1, 1'b1);
    chk("sat_hold", drop_count, 255);

    // Randomised traffic with occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400 == 0);
      cyc(32'($urandom_range(0, 5)), ($urandom % 4) != 0, ($urandom % 3) == 0);
    end
    reset = 1'b0;
    cyc(32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_out_capture.md
Name: program_out_capture

Overview:
- Downstream consumer of the multicycle computer's 32-bit `program_out` bus.
- Every time the value on `program_out` changes, the block records the new value in a small FIFO.
- Recorded values are presented on a valid/ready stream for a display, UART or testbench logger.
- Provides lossless trace of program output despite multi-cycle instruction timing; reports overflow when the sink stalls.

Parameters:
- DATA_WIDTH, 32, width of `program_out` and of each FIFO entry.
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 entries (default 8).
- DROP_CNT_WIDTH, 8, width of the saturating dropped-sample counter.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- program_out  in  DATA_WIDTH  output bus of the multicycle computer.
- capture_en  in  1  enables change detection; when low, no pushes occur and the previous-value register is frozen.
- out_data  out  DATA_WIDTH  FIFO head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts the head entry this cycle.
- fifo_count  out  DEPTH_LOG2+1  current occupancy, 0 to 2**DEPTH_LOG2.
- overflow  out  1  sticky; set on any dropped sample.
- drop_count  out  DROP_CNT_WIDTH  number of dropped samples, saturating.

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset values: `out_valid`=0, `out_data`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0. Read/write pointers and the previous-value register `prev` are all cleared to 0.
- Reset mid-operation discards all FIFO contents at the next edge; pending handshakes are abandoned.
- Change detect: push_req = `capture_en` && (`program_out` != `prev`).
- `prev` <= `program_out` on every edge where `capture_en`=1.
- A nonzero first value after reset therefore produces a push. A value of 0 does not.
- Latency: a value sampled at edge N is visible on `out_data` with `out_valid`=1 after edge N (registered write, combinational head read). With an empty FIFO, it is available in the cycle following the change.
- Pop: occurs when `out_valid` && `out_ready`. The head advances at that edge.
- While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- Empty: `out_ready` is ignored; no pointer movement. `out_data` holds the last read slot; the sink must qualify it with `out_valid`.
- Full, push and no pop: the sample is dropped. The FIFO is unchanged, `overflow` is set, and `drop_count` increments, saturating at 2**DROP_CNT_WIDTH-1.
- Full, push and pop in the same cycle: both happen, the sample is accepted, count stays at full, no drop.
- Non-full, push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo 2**DEPTH_LOG2. `fifo_count` is tracked explicitly so full and empty are unambiguous.
- `overflow` and `drop_count` clear only on reset.

Optional Feature:
- Macro: PROG_OUT_CAPTURE_TSTAMP_EN.
- When defined:
  - Adds a free-running 16-bit cycle counter, cleared by reset, wrapping 0xFFFF->0.
  - Adds port `out_ts` (out, 16): the counter value at the edge where the associated sample was pushed.
  - Each FIFO entry widens to DATA_WIDTH+16; `out_ts` follows the same stability rules as `out_data`.
- When undefined: no counter, no `out_ts` port, FIFO entries are DATA_WIDTH bits.

Decomposition:
- Shared package `mcc_pkg` holds:
  - DATA_WIDTH=32 (the codebase's data bus width)
  - the timestamp width constant TS_WIDTH=16
  - an entry typedef (data plus optional timestamp)
- One sub-module is natural: `sync_fifo`, a parameterised width/depth FIFO with push/pop, full/empty and count outputs. It is instantiated once.
- Change detect and drop accounting stay in the top module.

Test Plan:
- Reset held 5 cycles with `program_out`=0x1234 -> all outputs 0 throughout. First cycle after reset with `capture_en`=1 pushes 0x1234; next cycle `out_valid`=1, `out_data`=0x1234.
- `program_out` steps 0x1->0x2->0x2->0x3, `capture_en`=1, `out_ready`=1 -> exactly three outputs (0x1, 0x2, 0x3) in order; repeated 0x2 not captured.
- `out_ready`=0, 10 distinct values 0x10..0x19 -> `fifo_count`=8, `overflow`=1, `drop_count`=2. Draining yields 0x10..0x17.
- Full FIFO, a new value arrives in the same cycle `out_ready`=1 -> no drop, `drop_count` unchanged, `fifo_count` stays 8. The new value appears last.
- `capture_en`=0 while `program_out` changes 0x5->0x6, then `capture_en`=1 with 0x6 held -> one push of 0x6, since `prev` was frozen at its old value.
- With PROG_OUT_CAPTURE_TSTAMP_EN, push at cycle 3 and cycle 70000 after reset -> `out_ts`=3 and `out_ts`=4464 (wrapped).
